ex_pipe_unit: RTL and testbench
===============================

EX_PIPE_UNIT -- requirements
Module: ex_pipe_unit

Interface
REQ-001 Parameters SHALL be:
- XLEN, default 32: datapath width; legal values 32 or 64.
- FLUSH_CYCLES, default 4: number of cycles FLUSH stays high per mispredict; legal range 1..15.
- SQUASH_CYCLES, default 6: number of cycles SQUASH stays high per mispredict; legal range FLUSH_CYCLES..15.
- WARMUP, default 3: number of enabled cycles after reset before fall-through checking starts; legal range 0..7.

REQ-002 Ports SHALL be (name, direction, width, meaning):
- CLK  in  1  clock.
- RST  in  1  reset.
- CACHE_READY  in  1  global enable; low freezes all state.
- VALID_IN  in  1  instruction present.
- ALU_CNT  in  4  ALU operation.
- A  in  XLEN  operand.
- B  in  XLEN  operand.
- COMP_CNT  in  3  compare select.
- COMP1  in  XLEN  compare operand.
- COMP2  in  XLEN  compare operand.
- CBRANCH  in  1  conditional branch.
- JUMP  in  1  unconditional jump.
- JUMP_BUS1  in  XLEN  target term.
- JUMP_BUS2  in  XLEN  target term.
- PC_EX  in  XLEN  PC of this instruction.
- PC_NEXT  in  XLEN  PC fetched behind it.
- VALID_OUT  out  1  result valid.
- WB_DATA  out  XLEN  ALU result.
- DATA_ADDRESS  out  XLEN  A+B.
- JUMP_FINAL  out  1  redirect.
- JUMP_ADDR  out  XLEN  redirect target.
- FLUSH  out  1  front-end flush.
- SQUASH  out  1  internal kill.
- PREDICTED  out  1  combinational: 1 = no mispredict this cycle.

REQ-003 The block SHALL use one clock; reset SHALL be synchronous and active-high, with clock CLK and reset RST.

Function
REQ-004 All registered outputs SHALL update only on a CLK edge with CACHE_READY=1, with exactly one cycle of latency from the inputs.
REQ-005 ALU_CNT encoding SHALL be:
- 0 A+B; 1 B-A; 2 B<<A; 3 unsigned B<A; 4 A^B; 5 B>>A logical; 6 B>>A arithmetic.
- 7 A|B; 8 A&B; 9 A; 10 B; 11 signed B<A; 12 B+4.
- 13..15 give zero.
REQ-006 The shift amount SHALL be A[log2(XLEN)-1:0]; all sums SHALL be truncated modulo 2^XLEN.
REQ-007 COMP_CNT encoding SHALL be:
- 0 eq; 1 ne; 4 signed lt; 5 signed ge; 6 unsigned lt; 7 unsigned ge.
- 2 and 3 give 0.
REQ-008 The taken signal SHALL be VALID_IN & !SQUASH & (CBRANCH ? compare result : JUMP), and the target SHALL be JUMP_BUS1+JUMP_BUS2.
REQ-009 A mispredict SHALL be detected when either condition holds:
- taken & PC_NEXT!=target;
- VALID_IN & !taken & !SQUASH & warm & PC_NEXT!=PC_EX+4, where warm is 1 once the warm-up counter reaches WARMUP.
REQ-010 PREDICTED SHALL be !(mispredict & CACHE_READY).
REQ-011 The FSM SHALL have two states:
- IDLE goes to RECOVER on a mispredict; it loads flush_cnt=FLUSH_CYCLES and squash_cnt=SQUASH_CYCLES.
- In RECOVER, each enabled cycle decrements any nonzero counter; FLUSH=(flush_cnt!=0) and SQUASH=(squash_cnt!=0).
- RECOVER returns to IDLE when squash_cnt reaches 0.
REQ-012 Mispredicts detected while in RECOVER SHALL be ignored, and counters SHALL NOT reload.
REQ-013 While SQUASH=1 the following outputs SHALL be forced to 0: VALID_OUT, WB_DATA, JUMP_FINAL.
REQ-014 The warm-up counter SHALL saturate at WARMUP; with WARMUP=0, warm SHALL be 1 from the first enabled cycle.
REQ-015 When CACHE_READY=0, the FSM, counters and outputs SHALL hold their values.

Reset
REQ-016 RST=1 SHALL force the following state:
- FSM to IDLE;
- all counters to 0;
- these outputs to 0: FLUSH, SQUASH, VALID_OUT, WB_DATA, DATA_ADDRESS, JUMP_FINAL, JUMP_ADDR.
REQ-017 RST SHALL override CACHE_READY, and an RST during RECOVER SHALL abort recovery immediately.

Configuration
REQ-018 When macro EX_MISPRED_STATS_EN is defined, the block SHALL add output MISPRED_COUNT (16 bits):
- increments on each accepted mispredict (IDLE to RECOVER);
- saturates at 0xFFFF;
- resets to 0.
REQ-019 Without EX_MISPRED_STATS_EN, the MISPRED_COUNT port and its logic SHALL NOT exist, and all other behaviour SHALL be identical.

Verification
REQ-020 ALU case: ALU_CNT=6, B=0x80000000, A=4 -> next cycle WB_DATA=0xF8000000, VALID_OUT=1.
REQ-021 Taken-branch mispredict case: CBRANCH=1, COMP_CNT=0, COMP1=COMP2=5, JUMP_BUS1=0x100, JUMP_BUS2=0x20, PC_NEXT=0x104 ->
- PREDICTED=0 in the same cycle;
- JUMP_ADDR=0x120;
- FLUSH high 4 cycles and SQUASH high 6 cycles (default parameters).
REQ-022 Fall-through case: after warm-up, a non-branch with PC_EX=0x200 and PC_NEXT=0x300 -> mispredict; with PC_NEXT=0x204 -> PREDICTED=1 and FLUSH stays 0.
REQ-023 Stall case: CACHE_READY=0 for 3 cycles mid-RECOVER -> FLUSH/SQUASH durations extend by exactly 3 cycles.
REQ-024 Reset case: RST=1 asserted during RECOVER -> next cycle FLUSH=0 and SQUASH=0; a mispredict in the RECOVER window is ignored; MISPRED_COUNT counts 1 per accepted mispredict (when enabled).

Source files
------------

// File: rtl/ex_pipe_unit.sv
// Execute stage: ALU, branch compare/redirect, mispredict detection and flush/squash recovery FSM.
// Optional MISPRED_COUNT output is built when EX_MISPRED_STATS_EN is defined.
module ex_pipe_unit #(
  parameter int XLEN          = 32,
  parameter int FLUSH_CYCLES  = 4,
  parameter int SQUASH_CYCLES = 6,
  parameter int WARMUP        = 3
) (
  input  logic            CLK,
  input  logic            RST,
  input  logic            CACHE_READY,
  input  logic            VALID_IN,
  input  logic [3:0]      ALU_CNT,
  input  logic [XLEN-1:0] A,
  input  logic [XLEN-1:0] B,
  input  logic [2:0]      COMP_CNT,
  input  logic [XLEN-1:0] COMP1,
  input  logic [XLEN-1:0] COMP2,
  input  logic            CBRANCH,
  input  logic            JUMP,
  input  logic [XLEN-1:0] JUMP_BUS1,
  input  logic [XLEN-1:0] JUMP_BUS2,
  input  logic [XLEN-1:0] PC_EX,
  input  logic [XLEN-1:0] PC_NEXT,
  output logic            VALID_OUT,
  output logic [XLEN-1:0] WB_DATA,
  output logic [XLEN-1:0] DATA_ADDRESS,
  output logic            JUMP_FINAL,
  output logic [XLEN-1:0] JUMP_ADDR,
  output logic            FLUSH,
  output logic            SQUASH,
  output logic            PREDICTED
`ifdef EX_MISPRED_STATS_EN
  ,
  output logic [15:0]     MISPRED_COUNT
`endif
);

  localparam int SHW = $clog2(XLEN);
  localparam logic [XLEN-1:0] FOUR = XLEN'(4);

  typedef enum logic {IDLE, RECOVER} state_t;

  state_t          state_reg, state_next;
  logic [3:0]      flush_cnt_reg, flush_cnt_next;
  logic [3:0]      squash_cnt_reg, squash_cnt_next;
  logic [2:0]      warm_cnt_reg;
  logic            warm, cmp_res, taken, mispredict, kill_next;
  logic [XLEN-1:0] alu_res, target;
  logic [SHW-1:0]  shamt;

  assign shamt = A[SHW-1:0];

  always_comb begin
    alu_res = '0;
    case (ALU_CNT)
      4'd0:    alu_res = A + B;
      4'd1:    alu_res = B - A;
      4'd2:    alu_res = B << shamt;
      4'd3:    alu_res = {{(XLEN-1){1'b0}}, (B < A)};
      4'd4:    alu_res = A ^ B;
      4'd5:    alu_res = B >> shamt;
      4'd6:    alu_res = $unsigned($signed(B) >>> shamt);
      4'd7:    alu_res = A | B;
      4'd8:    alu_res = A & B;
      4'd9:    alu_res = A;
      4'd10:   alu_res = B;
      4'd11:   alu_res = {{(XLEN-1){1'b0}}, ($signed(B) < $signed(A))};
      4'd12:   alu_res = B + FOUR;
      default: alu_res = '0;
    endcase
  end

  always_comb begin
    cmp_res = 1'b0;
    case (COMP_CNT)
      3'd0:    cmp_res = (COMP1 == COMP2);
      3'd1:    cmp_res = (COMP1 != COMP2);
      3'd4:    cmp_res = ($signed(COMP1) < $signed(COMP2));
      3'd5:    cmp_res = ($signed(COMP1) >= $signed(COMP2));
      3'd6:    cmp_res = (COMP1 < COMP2);
      3'd7:    cmp_res = (COMP1 >= COMP2);
      default: cmp_res = 1'b0;
    endcase
  end

  // Fall-through checking is suppressed until the pipe has seen WARMUP enabled cycles.
  assign warm       = (warm_cnt_reg == 3'(WARMUP));
  assign target     = JUMP_BUS1 + JUMP_BUS2;
  assign taken      = VALID_IN & ~SQUASH & (CBRANCH ? cmp_res : JUMP);
  assign mispredict = (taken & (PC_NEXT != target)) |
                      (VALID_IN & ~taken & ~SQUASH & warm & (PC_NEXT != PC_EX + FOUR));
  assign PREDICTED  = ~(mispredict & CACHE_READY);
  assign FLUSH      = (flush_cnt_reg != 4'd0);
  assign SQUASH     = (squash_cnt_reg != 4'd0);

  always_comb begin
    state_next      = state_reg;
    flush_cnt_next  = flush_cnt_reg;
    squash_cnt_next = squash_cnt_reg;
    case (state_reg)
      IDLE: begin
        if (mispredict) begin
          state_next      = RECOVER;
          flush_cnt_next  = 4'(FLUSH_CYCLES);
          squash_cnt_next = 4'(SQUASH_CYCLES);
        end
      end
      RECOVER: begin
        if (flush_cnt_reg != 4'd0)  flush_cnt_next  = flush_cnt_reg - 4'd1;
        if (squash_cnt_reg != 4'd0) squash_cnt_next = squash_cnt_reg - 4'd1;
        if (squash_cnt_next == 4'd0) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Gate against the post-edge SQUASH so gated outputs are never visible alongside SQUASH=1.
  assign kill_next = (squash_cnt_next != 4'd0);

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_reg      <= IDLE;
      flush_cnt_reg  <= '0;
      squash_cnt_reg <= '0;
      warm_cnt_reg   <= '0;
      VALID_OUT      <= 1'b0;
      WB_DATA        <= '0;
      DATA_ADDRESS   <= '0;
      JUMP_FINAL     <= 1'b0;
      JUMP_ADDR      <= '0;
    end else if (CACHE_READY) begin
      state_reg      <= state_next;
      flush_cnt_reg  <= flush_cnt_next;
      squash_cnt_reg <= squash_cnt_next;
      if (warm_cnt_reg < 3'(WARMUP)) warm_cnt_reg <= warm_cnt_reg + 3'd1;
      VALID_OUT      <= VALID_IN & ~kill_next;
      WB_DATA        <= kill_next ? '0 : alu_res;
      DATA_ADDRESS   <= A + B;
      JUMP_FINAL     <= taken & ~kill_next;
      JUMP_ADDR      <= target;
    end
  end

`ifdef EX_MISPRED_STATS_EN
  logic [15:0] mispred_cnt_reg;
  logic        accept;

  assign accept        = (state_reg == IDLE) & mispredict;
  assign MISPRED_COUNT = mispred_cnt_reg;

  always_ff @(posedge CLK) begin
    if (RST) begin
      mispred_cnt_reg <= '0;
    end else if (CACHE_READY && accept && mispred_cnt_reg != 16'hFFFF) begin
      mispred_cnt_reg <= mispred_cnt_reg + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_ex_pipe_unit.sv
// Self-checking bench for ex_pipe_unit: vector table with scoreboard plus recovery/stall/reset sequences.
module tb_ex_pipe_unit;
  localparam int XLEN = 32;

  logic            CLK = 1'b0;
  logic            RST, CACHE_READY, VALID_IN, CBRANCH, JUMP;
  logic [3:0]      ALU_CNT;
  logic [2:0]      COMP_CNT;
  logic [XLEN-1:0] A, B, COMP1, COMP2, JUMP_BUS1, JUMP_BUS2, PC_EX, PC_NEXT;
  logic            VALID_OUT, JUMP_FINAL, FLUSH, SQUASH, PREDICTED;
  logic [XLEN-1:0] WB_DATA, DATA_ADDRESS, JUMP_ADDR;
`ifdef EX_MISPRED_STATS_EN
  logic [15:0]     MISPRED_COUNT;
`endif

  ex_pipe_unit #(.XLEN(XLEN), .FLUSH_CYCLES(4), .SQUASH_CYCLES(6), .WARMUP(3)) dut (
    .CLK(CLK), .RST(RST), .CACHE_READY(CACHE_READY), .VALID_IN(VALID_IN),
    .ALU_CNT(ALU_CNT), .A(A), .B(B), .COMP_CNT(COMP_CNT), .COMP1(COMP1), .COMP2(COMP2),
    .CBRANCH(CBRANCH), .JUMP(JUMP), .JUMP_BUS1(JUMP_BUS1), .JUMP_BUS2(JUMP_BUS2),
    .PC_EX(PC_EX), .PC_NEXT(PC_NEXT), .VALID_OUT(VALID_OUT), .WB_DATA(WB_DATA),
    .DATA_ADDRESS(DATA_ADDRESS), .JUMP_FINAL(JUMP_FINAL), .JUMP_ADDR(JUMP_ADDR),
    .FLUSH(FLUSH), .SQUASH(SQUASH), .PREDICTED(PREDICTED)
`ifdef EX_MISPRED_STATS_EN
    , .MISPRED_COUNT(MISPRED_COUNT)
`endif
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic [3:0]  alu;
    logic [31:0] a, b;
    logic [2:0]  cmp;
    logic [31:0] c1, c2;
    logic        cb, jmp;
    logic [31:0] wb;
    logic        jf;
  } vec_t;

  typedef struct {
    logic        v;
    logic [31:0] wb, da, ja;
    logic        jf;
  } exp_t;

  vec_t vecs[32];
  int   nvec = 0;
  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;
  int   exp_mcount = 0;

  function automatic void add(input logic [3:0] alu, input logic [31:0] a, input logic [31:0] b,
                              input logic [2:0] cmp, input logic [31:0] c1, input logic [31:0] c2,
                              input logic cb, input logic jmp, input logic [31:0] wb, input logic jf);
    vecs[nvec].alu = alu; vecs[nvec].a = a; vecs[nvec].b = b;
    vecs[nvec].cmp = cmp; vecs[nvec].c1 = c1; vecs[nvec].c2 = c2;
    vecs[nvec].cb = cb; vecs[nvec].jmp = jmp; vecs[nvec].wb = wb; vecs[nvec].jf = jf;
    nvec++;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic idle_in();
    VALID_IN = 0; CBRANCH = 0; JUMP = 0; ALU_CNT = 0; A = 0; B = 0;
    COMP_CNT = 0; COMP1 = 0; COMP2 = 0; JUMP_BUS1 = 0; JUMP_BUS2 = 0; PC_EX = 0; PC_NEXT = 0;
  endtask

  // Counts FLUSH/SQUASH cycles from the current cycle; optional 3-cycle stall and an in-window mispredict.
  task automatic measure(input string tag, input int stall_at, input bit inject,
                         input int exp_f, input int exp_s);
    int fl;
    int sq;
    fl = 0;
    sq = 0;
    idle_in();
    for (int c = 0; c < 60; c++) begin
      if (!SQUASH) break;
      if (FLUSH) fl++;
      sq++;
      if (inject && c == 2) chk({tag, "_kill_valid"}, 64'(VALID_OUT), 64'(0));
      CACHE_READY = !(c >= stall_at && c < stall_at + 3);
      VALID_IN = inject && (c == 1);
      PC_EX = 32'h200;
      PC_NEXT = 32'h300;
      #1;
      if (inject && c == 1) chk({tag, "_ignored"}, 64'(PREDICTED), 64'(1));
      @(posedge CLK);
      #1;
    end
    CACHE_READY = 1;
    idle_in();
    chk({tag, "_done"}, 64'(SQUASH), 64'(0));
    chk({tag, "_flush_len"}, 64'(fl), 64'(exp_f));
    chk({tag, "_squash_len"}, 64'(sq), 64'(exp_s));
    $display("recovery %s: flush=%0d squash=%0d", tag, fl, sq);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    exp_t e;
    //   alu    a             b             cmp  c1            c2          cb jmp wb            jf
    add(4'd0,  32'd5,        32'd7,        3'd0, 32'd0,       32'd1,      0, 0, 32'd12,       0);
    add(4'd0,  32'hFFFFFFFF, 32'd2,        3'd0, 32'd0,       32'd1,      0, 0, 32'd1,        0);
    add(4'd1,  32'd5,        32'd3,        3'd0, 32'd0,       32'd1,      0, 0, 32'hFFFFFFFE, 0);
    add(4'd2,  32'h24,       32'd3,        3'd0, 32'd0,       32'd1,      0, 0, 32'h30,       0);
    add(4'd3,  32'hFFFFFFFF, 32'd1,        3'd0, 32'd0,       32'd1,      0, 0, 32'd1,        0);
    add(4'd3,  32'd1,        32'hFFFFFFFF, 3'd0, 32'd0,       32'd1,      0, 0, 32'd0,        0);
    add(4'd4,  32'hF0F0F0F0, 32'hFF00FF00, 3'd0, 32'd0,       32'd1,      0, 0, 32'h0FF00FF0, 0);
    add(4'd5,  32'd4,        32'h80000000, 3'd0, 32'd0,       32'd1,      0, 0, 32'h08000000, 0);
    add(4'd6,  32'd4,        32'h80000000, 3'd0, 32'd0,       32'd1,      0, 0, 32'hF8000000, 0);
    add(4'd7,  32'h0F,       32'hF0,       3'd0, 32'd0,       32'd1,      0, 0, 32'hFF,       0);
    add(4'd8,  32'hFF00,     32'h0FF0,     3'd0, 32'd0,       32'd1,      0, 0, 32'h0F00,     0);
    add(4'd9,  32'h12345678, 32'd1,        3'd0, 32'd0,       32'd1,      0, 0, 32'h12345678, 0);
    add(4'd10, 32'd1,        32'hCAFEBABE, 3'd0, 32'd0,       32'd1,      0, 0, 32'hCAFEBABE, 0);
    add(4'd11, 32'd1,        32'hFFFFFFFF, 3'd0, 32'd0,       32'd1,      0, 0, 32'd1,        0);
    add(4'd12, 32'd0,        32'hFFFFFFFE, 3'd0, 32'd0,       32'd1,      0, 0, 32'd2,        0);
    add(4'd13, 32'd5,        32'd5,        3'd0, 32'd0,       32'd1,      0, 0, 32'd0,        0);
    add(4'd15, 32'd5,        32'd5,        3'd0, 32'd0,       32'd1,      0, 0, 32'd0,        0);
    add(4'd0,  32'd1,        32'd1,        3'd0, 32'd5,       32'd5,      1, 0, 32'd2,        1);
    add(4'd0,  32'd1,        32'd1,        3'd1, 32'd5,       32'd5,      1, 0, 32'd2,        0);
    add(4'd0,  32'd1,        32'd1,        3'd4, 32'hFFFFFFFF, 32'd1,     1, 0, 32'd2,        1);
    add(4'd0,  32'd1,        32'd1,        3'd5, 32'hFFFFFFFF, 32'd1,     1, 0, 32'd2,        0);
    add(4'd0,  32'd1,        32'd1,        3'd6, 32'hFFFFFFFF, 32'd1,     1, 0, 32'd2,        0);
    add(4'd0,  32'd1,        32'd1,        3'd7, 32'hFFFFFFFF, 32'd1,     1, 0, 32'd2,        1);
    add(4'd0,  32'd1,        32'd1,        3'd2, 32'd5,       32'd5,      1, 0, 32'd2,        0);
    add(4'd0,  32'd1,        32'd1,        3'd3, 32'd5,       32'd5,      1, 0, 32'd2,        0);
    add(4'd0,  32'd1,        32'd1,        3'd0, 32'd5,       32'd6,      0, 1, 32'd2,        1);

    RST = 1; CACHE_READY = 1; idle_in();
    repeat (2) @(posedge CLK);
    #1;
    chk("rst_valid", 64'(VALID_OUT), 64'(0));
    chk("rst_wb", 64'(WB_DATA), 64'(0));
    chk("rst_daddr", 64'(DATA_ADDRESS), 64'(0));
    chk("rst_jf", 64'(JUMP_FINAL), 64'(0));
    chk("rst_jaddr", 64'(JUMP_ADDR), 64'(0));
    chk("rst_flush", 64'(FLUSH), 64'(0));
    chk("rst_squash", 64'(SQUASH), 64'(0));
    chk("rst_predicted", 64'(PREDICTED), 64'(1));
`ifdef EX_MISPRED_STATS_EN
    chk("rst_count", 64'(MISPRED_COUNT), 64'(0));
`endif
    RST = 0;

    // Bad fall-through is tolerated during the three warm-up cycles, caught on the fourth.
    VALID_IN = 1; PC_EX = 32'h200; PC_NEXT = 32'h300;
    for (int c = 0; c < 3; c++) begin
      #1;
      chk($sformatf("warmup_c%0d", c), 64'(PREDICTED), 64'(1));
      @(posedge CLK);
      #1;
    end
    #1;
    chk("fallthru_mispred", 64'(PREDICTED), 64'(0));
    exp_mcount++;
    tick();
    chk("fallthru_flush", 64'(FLUSH), 64'(1));
    measure("fallthru", 100, 0, 4, 6);

    VALID_IN = 1; PC_EX = 32'h200; PC_NEXT = 32'h204; ALU_CNT = 4'd9; A = 32'h55;
    #1;
    chk("fallthru_ok_pred", 64'(PREDICTED), 64'(1));
    tick();
    chk("fallthru_ok_flush", 64'(FLUSH), 64'(0));
    chk("fallthru_ok_valid", 64'(VALID_OUT), 64'(1));
    chk("fallthru_ok_wb", 64'(WB_DATA), 64'(32'h55));
    idle_in();

    for (int i = 0; i < nvec; i++) begin
      VALID_IN = 1; ALU_CNT = vecs[i].alu; A = vecs[i].a; B = vecs[i].b;
      COMP_CNT = vecs[i].cmp; COMP1 = vecs[i].c1; COMP2 = vecs[i].c2;
      CBRANCH = vecs[i].cb; JUMP = vecs[i].jmp;
      PC_EX = 32'h1000; PC_NEXT = 32'h1004; JUMP_BUS1 = 32'h1000; JUMP_BUS2 = 32'h4;
      #1;
      chk($sformatf("vec%0d_pred", i), 64'(PREDICTED), 64'(1));
      e.v = 1'b1; e.wb = vecs[i].wb; e.da = vecs[i].a + vecs[i].b; e.ja = 32'h1004; e.jf = vecs[i].jf;
      sb.push_back(e);
      tick();
      if (sb.size() == 0) begin
        checks++; errors++;
        $display("FAIL vec%0d_sb: got empty scoreboard, want one entry", i);
      end else begin
        e = sb.pop_front();
        chk($sformatf("vec%0d_valid", i), 64'(VALID_OUT), 64'(e.v));
        chk($sformatf("vec%0d_wb", i), 64'(WB_DATA), 64'(e.wb));
        chk($sformatf("vec%0d_daddr", i), 64'(DATA_ADDRESS), 64'(e.da));
        chk($sformatf("vec%0d_jf", i), 64'(JUMP_FINAL), 64'(e.jf));
        chk($sformatf("vec%0d_jaddr", i), 64'(JUMP_ADDR), 64'(e.ja));
      end
      $display("vec %0d alu=%0d a=%h b=%h cmp=%0d -> wb=%h jf=%b", i, vecs[i].alu,
               vecs[i].a, vecs[i].b, vecs[i].cmp, WB_DATA, JUMP_FINAL);
    end
    idle_in();

    VALID_IN = 1; CBRANCH = 1; COMP_CNT = 3'd0; COMP1 = 5; COMP2 = 5;
    JUMP_BUS1 = 32'h100; JUMP_BUS2 = 32'h20; PC_EX = 32'h100; PC_NEXT = 32'h104;
    #1;
    chk("branch_pred", 64'(PREDICTED), 64'(0));
    exp_mcount++;
    tick();
    chk("branch_jaddr", 64'(JUMP_ADDR), 64'(32'h120));
    chk("branch_jf_killed", 64'(JUMP_FINAL), 64'(0));
    chk("branch_flush", 64'(FLUSH), 64'(1));
    measure("branch", 100, 1, 4, 6);

    VALID_IN = 1; JUMP = 1; JUMP_BUS1 = 32'h400; PC_NEXT = 32'h104;
    #1;
    chk("stall_pred", 64'(PREDICTED), 64'(0));
    exp_mcount++;
    tick();
    measure("stall", 2, 0, 7, 9);

    VALID_IN = 1; JUMP = 1; JUMP_BUS1 = 32'h400; PC_NEXT = 32'h104; A = 3; B = 4;
    #1;
    chk("rstrec_pred", 64'(PREDICTED), 64'(0));
    exp_mcount++;
    tick();
    idle_in();
    chk("rstrec_squash_on", 64'(SQUASH), 64'(1));
`ifdef EX_MISPRED_STATS_EN
    chk("count_before_rst", 64'(MISPRED_COUNT), 64'(exp_mcount));
`endif
    tick();
    CACHE_READY = 0; RST = 1;
    tick();
    exp_mcount = 0;
    chk("rstrec_flush", 64'(FLUSH), 64'(0));
    chk("rstrec_squash", 64'(SQUASH), 64'(0));
    chk("rstrec_jaddr", 64'(JUMP_ADDR), 64'(0));
    chk("rstrec_daddr", 64'(DATA_ADDRESS), 64'(0));
`ifdef EX_MISPRED_STATS_EN
    chk("count_after_rst", 64'(MISPRED_COUNT), 64'(0));
`endif
    RST = 0; CACHE_READY = 1;

    VALID_IN = 1; JUMP = 1; JUMP_BUS1 = 32'h400; PC_NEXT = 32'h104;
    #1;
    chk("postrst_pred", 64'(PREDICTED), 64'(0));
    exp_mcount++;
    tick();
    measure("postrst", 100, 0, 4, 6);
`ifdef EX_MISPRED_STATS_EN
    chk("count_final", 64'(MISPRED_COUNT), 64'(exp_mcount));
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
